// File: rtl/edge_detect_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : edge_detect_multi
// Brief    : Multi-channel synchronised, glitch-filtered edge detector with
//            per-channel mode select, one-cycle pulses and sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module edge_detect_multi #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int RESET_LEVEL   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clr,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     pulse,
    output logic [WIDTH-1:0]     flag,
    output logic                 irq
);

    localparam int                 C_CNT_W   = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(FILTER_CYCLES - 1);
    localparam logic               C_RST_LVL = RESET_LEVEL[0];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [C_CNT_W-1:0]     r_cnt;
        logic                   r_level;
        logic                   r_pulse;
        logic                   r_flag;
        logic                   w_s;
        logic [1:0]             w_mode;
        logic                   w_accept;
        logic                   w_pulse_next;

        assign w_s      = r_sync[SYNC_STAGES-1];
        assign w_mode   = mode[2*gi +: 2];
        assign w_accept = (w_s != r_level) && (r_cnt == C_CNT_MAX);
        // mode bit 0 qualifies rising edges, bit 1 falling edges
        assign w_pulse_next = w_accept & (w_s ? w_mode[0] : w_mode[1]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= {SYNC_STAGES{C_RST_LVL}};
            end else begin
                r_sync[0] <= in[gi];
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    r_sync[k] <= r_sync[k-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_level <= C_RST_LVL;
                r_pulse <= 1'b0;
                r_flag  <= 1'b0;
            end else begin
                r_pulse <= w_pulse_next;
                r_flag  <= w_pulse_next | (r_flag & ~clr[gi]);
                if (w_s == r_level) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_level <= w_s;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign level[gi] = r_level;
        assign pulse[gi] = r_pulse;
        assign flag[gi]  = r_flag;
    end

    assign irq = |flag;

endmodule
`default_nettype wire

// File: tb/tb_edge_detect_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_edge_detect_multi
// Brief    : Self-checking bench for edge_detect_multi with a window-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_detect_multi;

    localparam int W = 4;
    localparam int S = 2;
    localparam int F = 3;
    localparam int D = S + F - 1;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   in    = '0;
    logic [W-1:0]   clr   = '0;
    logic [2*W-1:0] mode  = '0;
    logic [W-1:0]   level, pulse, flag;
    logic           irq;

    logic           rst2_n = 1'b0;
    logic [1:0]     in2    = 2'b11;
    logic [1:0]     clr2   = 2'b00;
    logic [3:0]     mode2  = 4'b1111;
    logic [1:0]     level2, pulse2, flag2;
    logic           irq2;

    int n_checks = 0;
    int n_errors = 0;

    // Model: an edge is accepted once the last F synchronised samples all
    // disagree with the current level; samples are raw inputs delayed by S.
    logic [D-1:0]   m_hist [W];
    logic [W-1:0]   m_level, m_pulse, m_flag;

    edge_detect_multi #(
        .WIDTH(W), .SYNC_STAGES(S), .FILTER_CYCLES(F), .RESET_LEVEL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .clr(clr),
        .level(level), .pulse(pulse), .flag(flag), .irq(irq)
    );

    edge_detect_multi #(
        .WIDTH(2), .SYNC_STAGES(1), .FILTER_CYCLES(1), .RESET_LEVEL(1)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .in(in2), .mode(mode2), .clr(clr2),
        .level(level2), .pulse(pulse2), .flag(flag2), .irq(irq2)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int c = 0; c < W; c++) m_hist[c] = '0;
        m_level = '0;
        m_pulse = '0;
        m_flag  = '0;
    endtask

    task automatic model_edge();
        logic [W-1:0] nl, np;
        logic [F-1:0] win;
        for (int c = 0; c < W; c++) begin
            win   = m_hist[c][S-1 +: F];
            nl[c] = m_level[c];
            np[c] = 1'b0;
            if (win == {F{~m_level[c]}}) begin
                nl[c] = ~m_level[c];
                np[c] = nl[c] ? mode[2*c] : mode[2*c+1];
            end
            m_flag[c] = np[c] | (m_flag[c] & ~clr[c]);
            m_hist[c] = {m_hist[c][D-2:0], in[c]};
        end
        m_level = nl;
        m_pulse = np;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        mode = 8'h55;
        #12;
        n_checks++;
        if ({level, pulse, flag, irq} !== 13'b0) begin
            n_errors++;
            $display("FAIL reset_state: got lvl=%b pls=%b flg=%b irq=%b, expected all 0", level, pulse, flag, irq);
        end
        n_checks++;
        if ({level2, pulse2, flag2, irq2} !== 7'b11_00_00_0) begin
            n_errors++;
            $display("FAIL reset_state_lvl1: got lvl=%b pls=%b flg=%b irq=%b, expected lvl=11 rest 0", level2, pulse2, flag2, irq2);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
    endtask

    task automatic test_latency();
        int lat = 0;
        in[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (pulse[0]) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat != 5 || level[0] !== 1'b1 || flag[0] !== 1'b1 || irq !== 1'b1) begin
            n_errors++;
            $display("FAIL latency: got edges=%0d lvl=%b flg=%b irq=%b, expected 5 1 1 1", lat, level[0], flag[0], irq);
        end
        tick();
        n_checks++;
        if (pulse[0] !== 1'b0 || level[0] !== 1'b1 || flag[0] !== 1'b1 || irq !== 1'b1) begin
            n_errors++;
            $display("FAIL pulse_width: got pls=%b lvl=%b flg=%b irq=%b, expected 0 1 1 1", pulse[0], level[0], flag[0], irq);
        end
    endtask

    task automatic test_glitch();
        int  npls = 0;
        bit  saw_high = 1'b0;
        in[1] = 1'b1;
        tick();
        tick();
        in[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (pulse[1]) npls++;
            if (level[1]) saw_high = 1'b1;
        end
        n_checks++;
        if (npls != 0 || saw_high) begin
            n_errors++;
            $display("FAIL glitch_2cyc: got pulses=%0d level_seen_high=%0d, expected 0 0", npls, saw_high);
        end
        in[1] = 1'b1;
        tick();
        tick();
        tick();
        in[1] = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (pulse[1]) npls++;
            if (level[1]) saw_high = 1'b1;
        end
        n_checks++;
        if (npls != 1 || !saw_high || level[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_3cyc: got pulses=%0d high_seen=%0d final_lvl=%b, expected 1 1 0", npls, saw_high, level[1]);
        end
    endtask

    task automatic test_modes();
        int p[$];
        mode[5:4] = 2'b11;
        for (int k = 1; k <= 30; k++) begin
            in[2] = (k <= 10);
            tick();
            if (pulse[2]) p.push_back(k);
        end
        n_checks++;
        if (p.size() != 2 || p[0] != 5 || p[1] != 15) begin
            n_errors++;
            $display("FAIL mode_both: got %0d pulses first=%0d second=%0d, expected 2 at 5 and 15",
                     p.size(), (p.size() > 0) ? p[0] : -1, (p.size() > 1) ? p[1] : -1);
        end
        p.delete();
        mode[5:4] = 2'b10;
        for (int k = 1; k <= 30; k++) begin
            in[2] = (k <= 10);
            tick();
            if (pulse[2]) p.push_back(k);
        end
        n_checks++;
        if (p.size() != 1 || p[0] != 15) begin
            n_errors++;
            $display("FAIL mode_fall: got %0d pulses first=%0d, expected 1 at 15", p.size(), (p.size() > 0) ? p[0] : -1);
        end
    endtask

    task automatic test_clear();
        clr = 4'b1111;
        tick();
        clr = 4'b0000;
        tick();
        n_checks++;
        if (flag !== 4'b0000 || irq !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_all: got flg=%b irq=%b, expected 0000 0", flag, irq);
        end
        mode[7:6] = 2'b11;
        in[3] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (flag !== 4'b1000 || irq !== 1'b1) begin
            n_errors++;
            $display("FAIL flag_set: got flg=%b irq=%b, expected 1000 1", flag, irq);
        end
        in[3] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        clr[3] = 1'b1;
        tick();
        n_checks++;
        if (pulse[3] !== 1'b1 || flag[3] !== 1'b1) begin
            n_errors++;
            $display("FAIL set_beats_clear: got pls=%b flg=%b, expected 1 1", pulse[3], flag[3]);
        end
        tick();
        clr[3] = 1'b0;
        n_checks++;
        if (flag !== 4'b0000 || irq !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_one: got flg=%b irq=%b, expected 0000 0", flag, irq);
        end
    endtask

    task automatic test_reset_edge();
        in    = 4'b1111;
        mode  = 8'h55;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (pulse !== ((k == 5) ? 4'b1111 : 4'b0000)) begin
                n_errors++;
                $display("FAIL release_edge k=%0d: got pls=%b, expected %b", k, pulse, (k == 5) ? 4'b1111 : 4'b0000);
            end
        end
        in = 4'b0000;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({level, pulse, flag, irq} !== 13'b0) begin
            n_errors++;
            $display("FAIL reset_midfilter: got lvl=%b pls=%b flg=%b irq=%b, expected all 0", level, pulse, flag, irq);
        end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_small();
        n_checks++;
        if (level2 !== 2'b11 || pulse2 !== 2'b00 || flag2 !== 2'b00) begin
            n_errors++;
            $display("FAIL small_idle: got lvl=%b pls=%b flg=%b, expected 11 00 00", level2, pulse2, flag2);
        end
        in2[0] = 1'b0;
        tick();
        in2[0] = 1'b1;
        n_checks++;
        if (level2 !== 2'b11 || pulse2 !== 2'b00) begin
            n_errors++;
            $display("FAIL small_e1: got lvl=%b pls=%b, expected 11 00", level2, pulse2);
        end
        tick();
        n_checks++;
        if (level2 !== 2'b10 || pulse2 !== 2'b01) begin
            n_errors++;
            $display("FAIL small_fall: got lvl=%b pls=%b, expected 10 01", level2, pulse2);
        end
        tick();
        n_checks++;
        if (level2 !== 2'b11 || pulse2 !== 2'b01) begin
            n_errors++;
            $display("FAIL small_rise: got lvl=%b pls=%b, expected 11 01", level2, pulse2);
        end
        tick();
        n_checks++;
        if (pulse2 !== 2'b00 || flag2 !== 2'b01 || irq2 !== 1'b1) begin
            n_errors++;
            $display("FAIL small_after: got pls=%b flg=%b irq=%b, expected 00 01 1", pulse2, flag2, irq2);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(5) == 0) in[c] = ~in[c];
                clr[c] = ($urandom_range(7) == 0);
            end
            if ($urandom_range(19) == 0) mode = 8'($urandom);
            if (k == 200) begin
                rst_n = 1'b0;
                model_reset();
                #2;
                n_checks++;
                if ({level, pulse, flag, irq} !== 13'b0) begin
                    n_errors++;
                    $display("FAIL random_reset: got lvl=%b pls=%b flg=%b irq=%b, expected all 0", level, pulse, flag, irq);
                end
                #2;
                rst_n = 1'b1;
            end
            tick();
            n_checks++;
            if ({level, pulse, flag, irq} !== {m_level, m_pulse, m_flag, |m_flag}) begin
                n_errors++;
                $display("FAIL random k=%0d: got lvl=%b pls=%b flg=%b irq=%b, expected lvl=%b pls=%b flg=%b irq=%b",
                         k, level, pulse, flag, irq, m_level, m_pulse, m_flag, |m_flag);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_modes();
        test_clear();
        test_reset_edge();
        test_small();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
